instr_sequencer: RTL and testbench

Fetch–decode–execute sequencer for the 8-bit simple processor. Fetches 8-bit instructions (opcode in [7:4], operand in [3:0]) from the shared 16×8 RAM, drives RAM read/write strobes and the ALU start/done handshake, and holds the accumulator, B register, PC and IR. It replaces manual key-driven stepping with run and single-step control, so the datapath executes programs autonomously.

---
 rtl/instr_sequencer.sv | 178 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/execute sequencer for the 8-bit simple processor
// Drives RAM and ALU handshakes; holds acc, b_reg, pc and ir; run and single-step control.
module instr_sequencer #(
  parameter int DATA_W      = 8,
  parameter int ALU_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  output logic [3:0]        mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_rd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  output logic              alu_start,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_done,
  output logic [3:0]        pc,
  output logic [DATA_W-1:0] acc,
  output logic [7:0]        ir,
  output logic              halted,
  output logic              illegal,
  output logic              instr_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_FETCH_WAIT, S_DECODE, S_MEM_WAIT, S_ALU_WAIT, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_LDB = 4'h4;
  localparam logic [3:0] OP_ALU = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t              state, state_n;
  logic [3:0]          pc_n;
  logic [DATA_W-1:0]   acc_n, b_reg, b_reg_n;
  logic [7:0]          ir_n;
  logic                halted_n, illegal_n, end_instr;
  logic [7:0]          tmo_cnt, tmo_cnt_n;
  logic [3:0]          opcode, operand;

  assign opcode  = ir[7:4];
  assign operand = ir[3:0];
  assign mem_din = acc;
  assign alu_a   = acc;
  assign alu_b   = b_reg;
  assign alu_op  = ir[2:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      acc     <= '0;
      b_reg   <= '0;
      ir      <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      acc     <= acc_n;
      b_reg   <= b_reg_n;
      ir      <= ir_n;
      halted  <= halted_n;
      illegal <= illegal_n;
      tmo_cnt <= tmo_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    acc_n      = acc;
    b_reg_n    = b_reg;
    ir_n       = ir;
    halted_n   = halted;
    illegal_n  = illegal;
    tmo_cnt_n  = tmo_cnt;
    mem_addr   = pc;
    mem_rd     = 1'b0;
    mem_we     = 1'b0;
    alu_start  = 1'b0;
    instr_done = 1'b0;
    end_instr  = 1'b0;

    case (state)
      S_IDLE: begin
        if (run || step) state_n = S_FETCH;
      end
      S_FETCH: begin
        mem_rd  = 1'b1;
        state_n = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        ir_n    = mem_dout[7:0];
        pc_n    = pc + 4'd1;
        state_n = S_DECODE;
      end
      S_DECODE: begin
        mem_addr = operand;
        case (opcode)
          OP_NOP: end_instr = 1'b1;
          OP_LDI: begin
            acc_n     = {{(DATA_W-4){1'b0}}, operand};
            end_instr = 1'b1;
          end
          OP_LDA, OP_LDB: begin
            mem_rd  = 1'b1;
            state_n = S_MEM_WAIT;
          end
          OP_STA: begin
            mem_we    = 1'b1;
            end_instr = 1'b1;
          end
          OP_ALU: begin
            alu_start = 1'b1;
            tmo_cnt_n = '0;
            state_n   = S_ALU_WAIT;
          end
          OP_JMP: begin
            pc_n      = operand;
            end_instr = 1'b1;
          end
          OP_JZ: begin
            if (acc == '0) pc_n = operand;
            end_instr = 1'b1;
          end
          OP_HLT: begin
            halted_n   = 1'b1;
            instr_done = 1'b1;
            state_n    = S_HALT;
          end
          default: begin
            illegal_n = 1'b1;
            end_instr = 1'b1;
          end
        endcase
      end
      S_MEM_WAIT: begin
        if (opcode == OP_LDA) acc_n = mem_dout;
        else                  b_reg_n = mem_dout;
        end_instr = 1'b1;
      end
      S_ALU_WAIT: begin
        // A late completion on the last allowed cycle still wins over the timeout.
        if (alu_done) begin
          acc_n     = alu_result;
          end_instr = 1'b1;
        end else if (tmo_cnt == 8'(ALU_TIMEOUT - 1)) begin
          halted_n  = 1'b1;
          illegal_n = 1'b1;
          state_n   = S_HALT;
        end else begin
          tmo_cnt_n = tmo_cnt + 8'd1;
        end
      end
      S_HALT: state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase

    if (end_instr) begin
      instr_done = 1'b1;
      state_n    = run ? S_FETCH : S_IDLE;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench for instr_sequencer
// Bench RAM and ALU models plus an instruction-level reference model of the processor.
module tb_instr_sequencer;

  localparam int ALU_TIMEOUT = 15;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [3:0] mem_addr;
  logic [7:0] mem_din, mem_dout, alu_a, alu_b, alu_result, acc, ir;
  logic       mem_rd, mem_we, alu_start, alu_done, halted, illegal, instr_done;
  logic [2:0] alu_op;
  logic [3:0] pc;

  int checks = 0;
  int errors = 0;

  instr_sequencer #(.DATA_W(8), .ALU_TIMEOUT(ALU_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .run(run), .step(step),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_we(mem_we),
    .mem_dout(mem_dout), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_start(alu_start), .alu_result(alu_result), .alu_done(alu_done),
    .pc(pc), .acc(acc), .ir(ir), .halted(halted), .illegal(illegal),
    .instr_done(instr_done)
  );

  always #5 clock = ~clock;

  // RAM: synchronous read (data the cycle after mem_rd), bench load port.
  logic [7:0] ram [16];
  logic       ld_en = 1'b0;
  logic [3:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  always @(posedge clock) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (mem_we) ram[mem_addr] <= mem_din;
    if (mem_rd) mem_dout <= ram[mem_addr];
  end

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a << 1;
      default: return b;
    endcase
  endfunction

  // ALU: answers alu_lat cycles after alu_start; alu_lat = 0 means never.
  int         alu_lat = 1;
  int         alu_cd;
  logic [7:0] alu_la, alu_lb;
  logic [2:0] alu_lop;
  always @(posedge clock) begin
    if (!reset) alu_cd <= 0;
    else if (alu_start) begin
      alu_cd  <= alu_lat;
      alu_la  <= alu_a;
      alu_lb  <= alu_b;
      alu_lop <= alu_op;
    end else if (alu_cd > 0) alu_cd <= alu_cd - 1;
  end
  assign alu_done   = (alu_cd == 1);
  assign alu_result = alu_fn(alu_la, alu_lb, alu_lop);

  // Instruction-level reference model.
  logic [7:0] img [16];
  logic [7:0] m_ram [16];
  logic [7:0] m_acc, m_b, m_ir;
  logic [3:0] m_pc;
  logic       m_halt, m_ill;

  task automatic model_exec(input int lat, output int exp_lat);
    logic [3:0] opc, opd;
    m_ir = m_ram[m_pc];
    m_pc = m_pc + 4'd1;
    opc = m_ir[7:4];
    opd = m_ir[3:0];
    exp_lat = 3;
    case (opc)
      4'h0: ;
      4'h1: m_acc = {4'h0, opd};
      4'h2: begin m_acc = m_ram[opd]; exp_lat = 4; end
      4'h3: m_ram[opd] = m_acc;
      4'h4: begin m_b = m_ram[opd]; exp_lat = 4; end
      4'h5: begin
        if (lat == 0) begin
          m_halt = 1'b1; m_ill = 1'b1; exp_lat = 4 + ALU_TIMEOUT;
        end else begin
          m_acc = alu_fn(m_acc, m_b, opd[2:0]); exp_lat = 3 + lat;
        end
      end
      4'h6: m_pc = opd;
      4'h7: if (m_acc == 8'h00) m_pc = opd;
      4'hF: m_halt = 1'b1;
      default: m_ill = 1'b1;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; run = 1'b0; step = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 16; i++) begin
      ld_en = 1'b1; ld_addr = 4'(i); ld_data = img[i];
      m_ram[i] = img[i];
      @(negedge clock);
    end
    ld_en = 1'b0;
    m_acc = '0; m_b = '0; m_ir = '0; m_pc = '0; m_halt = 1'b0; m_ill = 1'b0;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic run_step(input int lat);
    int el, n;
    model_exec(lat, el);
    alu_lat = lat;
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
    n = 1;
    while (!(instr_done || halted) && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("latency", n, el);
    @(negedge clock);
    check("acc", acc, m_acc);
    check("pc", pc, m_pc);
    check("ir", ir, m_ir);
    check("halted", halted, m_halt);
    check("illegal", illegal, m_ill);
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, pulses, el, rd_seen;
    logic [3:0] p15;
    logic [3:0] op4;

    // Reset values
    clear_img();
    do_reset();
    check("rst_pc", pc, 0);
    check("rst_acc", acc, 0);
    check("rst_ir", ir, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_alu_start", alu_start, 0);
    check("rst_instr_done", instr_done, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_alu_op", alu_op, 0);

    // Continuous run: LDI 3; STA A; LDA A; HLT
    clear_img();
    img[0] = 8'h13; img[1] = 8'h3A; img[2] = 8'h2A; img[3] = 8'hF0;
    do_reset();
    run = 1'b1;
    cyc = 0; pulses = 0;
    while (!halted && cyc < 200) begin
      @(negedge clock); cyc++;
      if (instr_done) pulses++;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (instr_done) pulses++;
    end
    run = 1'b0;
    check("prog_acc", acc, 8'h03);
    check("prog_ram_a", ram[10], 8'h03);
    check("prog_halted", halted, 1);
    check("prog_illegal", illegal, 0);
    check("prog_pc", pc, 4);
    check("prog_pulses", pulses, 4);

    // JZ not taken, then taken
    clear_img();
    img[0] = 8'h15; img[1] = 8'h70;
    do_reset();
    run_step(1); run_step(1);
    check("jz_not_taken_pc", pc, 2);
    clear_img();
    img[0] = 8'h10; img[1] = 8'h73;
    do_reset();
    run_step(1); run_step(1);
    check("jz_taken_pc", pc, 3);

    // LDI 7; LDB E; ALU sub with 4-cycle ALU
    clear_img();
    img[0] = 8'h17; img[1] = 8'h4E; img[2] = 8'h51; img[14] = 8'h25;
    do_reset();
    run_step(1); run_step(1); run_step(4);
    check("alu_acc", acc, 8'hE2);

    // ALU never answers: timeout halts
    clear_img();
    img[0] = 8'h13; img[1] = 8'h53;
    do_reset();
    run_step(1); run_step(0);
    check("tmo_acc", acc, 8'h03);
    run = 1'b1;
    step = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      step = 1'b0;
      if (instr_done) pulses++;
    end
    run = 1'b0;
    check("halt_sticky_pc", pc, 2);
    check("halt_no_done", pulses, 0);

    // Single step with an extra pulse mid-instruction
    clear_img();
    do_reset();
    model_exec(1, el);
    step = 1'b1; @(negedge clock); step = 1'b0;
    @(negedge clock);
    step = 1'b1; @(negedge clock); step = 1'b0;
    pulses = (instr_done) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (instr_done) pulses++;
    end
    check("step_extra_pulses", pulses, 1);
    check("step_extra_pc", pc, 1);
    run_step(1); run_step(1);
    rd_seen = 0; pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (mem_rd) rd_seen++;
      if (instr_done) pulses++;
    end
    check("step_pc", pc, 3);
    check("step_idle_rd", rd_seen, 0);
    check("step_idle_done", pulses, 0);

    // 16 NOPs in run mode: pc wraps, back-to-back instructions
    clear_img();
    do_reset();
    run = 1'b1;
    cyc = 0; pulses = 0; p15 = 4'h0;
    while (pulses < 16 && cyc < 200) begin
      @(negedge clock); cyc++;
      if (instr_done) begin
        pulses++;
        if (pulses == 15) p15 = pc;
        if (pulses == 16) run = 1'b0;
      end
    end
    check("wrap_cycles", cyc, 48);
    check("wrap_pc15", p15, 15);
    check("wrap_pc", pc, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (instr_done) pulses++;
    end
    check("wrap_stop_pc", pc, 0);
    check("wrap_stop_done", pulses, 0);

    // Reset mid-STA
    clear_img();
    img[0] = 8'h15; img[1] = 8'h3A; img[10] = 8'h99;
    do_reset();
    run_step(1);
    step = 1'b1; @(negedge clock); step = 1'b0;
    cyc = 0;
    while (!mem_we && cyc < 10) begin
      @(negedge clock); cyc++;
    end
    check("sta_we_seen", mem_we, 1);
    reset = 1'b0;
    #1;
    check("rsta_mem_we", mem_we, 0);
    check("rsta_mem_rd", mem_rd, 0);
    check("rsta_instr_done", instr_done, 0);
    check("rsta_pc", pc, 0);
    check("rsta_acc", acc, 0);
    check("rsta_ir", ir, 0);
    check("rsta_mem_addr", mem_addr, 0);
    check("rsta_alu_op", alu_op, 0);
    check("rsta_halted", halted, 0);
    @(negedge clock); @(negedge clock);
    check("rsta_ram_a", ram[10], 8'h99);
    reset = 1'b1;

    // Random programs, one step at a time against the reference model
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 16; i++) begin
        op4 = 4'($urandom_range(0, 15));
        if (op4 == 4'hF && $urandom_range(0, 3) != 0) op4 = 4'h1;
        img[i] = {op4, 4'($urandom_range(0, 15))};
      end
      do_reset();
      for (int s = 0; s < 10 && !m_halt; s++) run_step($urandom_range(1, 4));
      for (int i = 0; i < 16; i++) check("rand_ram", ram[i], m_ram[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
